// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - ISA opcode/funct constants and shared helpers for the scheduler
package core_pkg;

  localparam logic [5:0] _RType = 6'h00;
  localparam logic [5:0] _lw    = 6'h23;
  localparam logic [5:0] _sw    = 6'h2b;
  localparam logic [5:0] _beq   = 6'h04;
  localparam logic [5:0] _bne   = 6'h05;
  localparam logic [5:0] _j     = 6'h02;
  localparam logic [5:0] _jal   = 6'h03;
  localparam logic [5:0] _addi  = 6'h08;
  localparam logic [5:0] _ori   = 6'h0d;
  localparam logic [5:0] _xori  = 6'h0e;
  localparam logic [5:0] _andi  = 6'h0c;
  localparam logic [5:0] _slti  = 6'h0a;
  localparam logic [5:0] _jr_   = 6'h08;

  localparam logic [4:0] REG_RA = 5'd31;

  function automatic logic src_hit(input logic use_rs, input logic [4:0] rs,
                                   input logic use_rt, input logic [4:0] rt,
                                   input logic [4:0] r);
    return (use_rs && (rs == r)) || (use_rt && (rt == r));
  endfunction

endpackage

// File: rtl/issue_classify.sv
// rtl/issue_classify.sv - decodes one instruction into the hazard attributes used for pairing
module issue_classify
  import core_pkg::*;
(
  input  logic [31:0] instr,
  output logic        is_mem,
  output logic        is_load,
  output logic        is_ctrl,
  output logic        has_dest,
  output logic [4:0]  dest,
  output logic        use_rs,
  output logic        use_rt,
  output logic [4:0]  rs,
  output logic [4:0]  rt
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] dest_raw;
  logic       dest_en;
  logic       unused_shamt;

  assign op           = instr[31:26];
  assign funct        = instr[5:0];
  assign rs           = instr[25:21];
  assign rt           = instr[20:16];
  assign unused_shamt = ^instr[10:6];

  always_comb begin
    is_mem   = 1'b0;
    is_load  = 1'b0;
    is_ctrl  = 1'b0;
    dest_en  = 1'b0;
    dest_raw = 5'd0;
    use_rs   = 1'b0;
    use_rt   = 1'b0;
    case (op)
      _RType: begin
        use_rs = 1'b1;
        if (funct == _jr_) begin
          is_ctrl = 1'b1;
        end else begin
          use_rt   = 1'b1;
          dest_en  = 1'b1;
          dest_raw = instr[15:11];
        end
      end
      _lw: begin
        is_mem   = 1'b1;
        is_load  = 1'b1;
        use_rs   = 1'b1;
        dest_en  = 1'b1;
        dest_raw = rt;
      end
      _sw: begin
        is_mem = 1'b1;
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      _beq, _bne: begin
        is_ctrl = 1'b1;
        use_rs  = 1'b1;
        use_rt  = 1'b1;
      end
      _j: is_ctrl = 1'b1;
      _jal: begin
        is_ctrl  = 1'b1;
        dest_en  = 1'b1;
        dest_raw = REG_RA;
      end
      _addi, _ori, _xori, _andi, _slti: begin
        use_rs   = 1'b1;
        dest_en  = 1'b1;
        dest_raw = rt;
      end
      default: ;
    endcase
  end

  // $0 is never a real destination, so it cannot create RAW/WAW hazards
  assign has_dest = dest_en && (dest_raw != 5'd0);
  assign dest     = has_dest ? dest_raw : 5'd0;

endmodule

// File: rtl/dual_issue_scheduler.sv
// rtl/dual_issue_scheduler.sv - 4-entry pair queue issuing up to two in-order instructions per cycle
module dual_issue_scheduler
  import core_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_valid,
  input  logic [31:0]      fetch_instr0,
  input  logic [31:0]      fetch_instr1,
  input  logic [31:0]      fetch_pc,
  output logic             fetch_ready,
  input  logic             flush,
  input  logic             stall,
  output logic             issue0_valid,
  output logic [31:0]      issue0_instr,
  output logic [31:0]      issue0_pc,
  output logic             issue1_valid,
  output logic [31:0]      issue1_instr,
  output logic [31:0]      issue1_pc,
  output logic [PTR_W:0]   occupancy
);

  localparam int CNT_W = PTR_W + 1;

  logic [31:0]      instr_mem_q [DEPTH];
  logic [31:0]      instr_mem_d [DEPTH];
  logic [31:0]      pc_mem_q    [DEPTH];
  logic [31:0]      pc_mem_d    [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, head1, tail1;
  logic [CNT_W-1:0] count_q, count_d, pops;
  logic             ld_valid_q, ld_valid_d;
  logic [4:0]       ld_reg_q, ld_reg_d;
  logic             push;

  logic       mem0, load0, ctrl0, hd0, urs0, urt0;
  logic       mem1, load1, ctrl1, hd1, urs1, urt1;
  logic [4:0] dest0, rs0, rt0, dest1, rs1, rt1;
  logic       lu0, lu1, pair_ok, unused_ctrl1;

  assign head1 = head_q + PTR_W'(1);
  assign tail1 = tail_q + PTR_W'(1);

  assign issue0_instr = instr_mem_q[head_q];
  assign issue0_pc    = pc_mem_q[head_q];
  assign issue1_instr = instr_mem_q[head1];
  assign issue1_pc    = pc_mem_q[head1];

  issue_classify u_cls0 (
    .instr(issue0_instr), .is_mem(mem0), .is_load(load0), .is_ctrl(ctrl0),
    .has_dest(hd0), .dest(dest0), .use_rs(urs0), .use_rt(urt0), .rs(rs0), .rt(rt0)
  );

  issue_classify u_cls1 (
    .instr(issue1_instr), .is_mem(mem1), .is_load(load1), .is_ctrl(ctrl1),
    .has_dest(hd1), .dest(dest1), .use_rs(urs1), .use_rt(urt1), .rs(rs1), .rt(rt1)
  );

  assign unused_ctrl1 = ctrl1;

  assign fetch_ready = (count_q <= CNT_W'(DEPTH - 2));
  assign occupancy   = count_q;
  assign push        = fetch_valid && fetch_ready && !flush;

  assign lu0 = ld_valid_q && src_hit(urs0, rs0, urt0, rt0, ld_reg_q);
  assign lu1 = ld_valid_q && src_hit(urs1, rs1, urt1, rt1, ld_reg_q);

  // A control instruction in lane 0 closes the group; lane 1 must be hazard-free against lane 0
  assign pair_ok = !(mem0 && mem1) && !ctrl0
                && !(hd0 && src_hit(urs1, rs1, urt1, rt1, dest0))
                && !(hd0 && hd1 && (dest0 == dest1));

  assign issue0_valid = (count_q >= CNT_W'(1)) && !stall && !flush && !lu0;
  assign issue1_valid = issue0_valid && (count_q >= CNT_W'(2)) && !flush && !lu1 && pair_ok;
  assign pops         = CNT_W'(issue0_valid) + CNT_W'(issue1_valid);

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    ld_valid_d  = ld_valid_q;
    ld_reg_d    = ld_reg_q;
    instr_mem_d = instr_mem_q;
    pc_mem_d    = pc_mem_q;
    if (flush) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      ld_valid_d = 1'b0;
      ld_reg_d   = 5'd0;
    end else begin
      if (push) begin
        instr_mem_d[tail_q] = fetch_instr0;
        instr_mem_d[tail1]  = fetch_instr1;
        pc_mem_d[tail_q]    = fetch_pc;
        pc_mem_d[tail1]     = fetch_pc + 32'd4;
        tail_d              = tail_q + PTR_W'(2);
      end
      head_d  = head_q + PTR_W'(pops);
      count_d = count_q + (push ? CNT_W'(2) : CNT_W'(0)) - pops;
      if (!stall) begin
        // Track the youngest load of this group so its consumer waits one cycle
        if (issue1_valid && load1 && hd1) begin
          ld_valid_d = 1'b1;
          ld_reg_d   = dest1;
        end else if (issue0_valid && load0 && hd0 && !issue1_valid) begin
          ld_valid_d = 1'b1;
          ld_reg_d   = dest0;
        end else if (issue0_valid && load0 && hd0 && !(load1 && hd1)) begin
          ld_valid_d = 1'b1;
          ld_reg_d   = dest0;
        end else begin
          ld_valid_d = 1'b0;
          ld_reg_d   = 5'd0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      ld_valid_q <= 1'b0;
      ld_reg_q   <= 5'd0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      ld_valid_q <= ld_valid_d;
      ld_reg_q   <= ld_reg_d;
    end
  end

  always_ff @(posedge clk) begin
    instr_mem_q <= instr_mem_d;
    pc_mem_q    <= pc_mem_d;
  end

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// tb/tb_dual_issue_scheduler.sv - directed self-checking bench for dual_issue_scheduler
module tb_dual_issue_scheduler;

  logic        clk, rst;
  logic        fetch_valid, fetch_ready, flush, stall;
  logic [31:0] fetch_instr0, fetch_instr1, fetch_pc;
  logic        issue0_valid, issue1_valid;
  logic [31:0] issue0_instr, issue0_pc, issue1_instr, issue1_pc;
  logic [2:0]  occupancy;
  int          errors, checks;

  dual_issue_scheduler #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_instr0(fetch_instr0), .fetch_instr1(fetch_instr1),
    .fetch_pc(fetch_pc), .fetch_ready(fetch_ready), .flush(flush), .stall(stall),
    .issue0_valid(issue0_valid), .issue0_instr(issue0_instr), .issue0_pc(issue0_pc),
    .issue1_valid(issue1_valid), .issue1_instr(issue1_instr), .issue1_pc(issue1_pc),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_pair(input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] pc);
    fetch_valid  = 1'b1;
    fetch_instr0 = i0;
    fetch_instr1 = i1;
    fetch_pc     = pc;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", fetch_ready); end
    checks++; if (issue0_valid !== 1'b0) begin errors++; $display("FAIL reset_v0 got %0b exp 0", issue0_valid); end
    checks++; if (issue1_valid !== 1'b0) begin errors++; $display("FAIL reset_v1 got %0b exp 0", issue1_valid); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
    next_cycle();
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_independent();
    drive_pair(rtype(5'd2, 5'd3, 5'd1, 6'h20), rtype(5'd5, 5'd6, 5'd4, 6'h25), 32'h100);
    #1;
    checks++; if (issue0_valid !== 1'b0) begin errors++; $display("FAIL indep_nobypass got %0b exp 0", issue0_valid); end
    next_cycle();
    fetch_valid = 1'b0;
    #1;
    checks++; if (occupancy !== 3'd2) begin errors++; $display("FAIL indep_occ2 got %0d exp 2", occupancy); end
    checks++; if ({issue0_valid, issue1_valid} !== 2'b11) begin errors++; $display("FAIL indep_valids got %b exp 11", {issue0_valid, issue1_valid}); end
    checks++; if (issue0_pc !== 32'h100) begin errors++; $display("FAIL indep_pc0 got %h exp 100", issue0_pc); end
    checks++; if (issue1_pc !== 32'h104) begin errors++; $display("FAIL indep_pc1 got %h exp 104", issue1_pc); end
    checks++; if (issue1_instr !== rtype(5'd5, 5'd6, 5'd4, 6'h25)) begin errors++; $display("FAIL indep_instr1 got %h", issue1_instr); end
    next_cycle();
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL indep_occ0 got %0d exp 0", occupancy); end
  endtask

  task automatic test_raw();
    drive_pair(itype(6'h08, 5'd0, 5'd1, 16'd5), rtype(5'd1, 5'd1, 5'd2, 6'h20), 32'h200);
    next_cycle();
    fetch_valid = 1'b0;
    #1;
    checks++; if ({issue0_valid, issue1_valid} !== 2'b10) begin errors++; $display("FAIL raw_c1 got %b exp 10", {issue0_valid, issue1_valid}); end
    next_cycle();
    checks++; if (issue0_valid !== 1'b1 || issue0_pc !== 32'h204) begin errors++; $display("FAIL raw_c2 got v=%0b pc=%h exp v=1 pc=204", issue0_valid, issue0_pc); end
    checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL raw_occ got %0d exp 1", occupancy); end
    next_cycle();
  endtask

  task automatic test_load_use();
    drive_pair(itype(6'h23, 5'd9, 5'd8, 16'd0), rtype(5'd8, 5'd8, 5'd10, 6'h20), 32'h300);
    next_cycle();
    fetch_valid = 1'b0;
    #1;
    checks++; if ({issue0_valid, issue1_valid} !== 2'b10) begin errors++; $display("FAIL lu_lw got %b exp 10", {issue0_valid, issue1_valid}); end
    next_cycle();
    checks++; if ({issue0_valid, issue1_valid} !== 2'b00) begin errors++; $display("FAIL lu_bubble got %b exp 00", {issue0_valid, issue1_valid}); end
    checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL lu_bubble_occ got %0d exp 1", occupancy); end
    next_cycle();
    checks++; if (issue0_valid !== 1'b1 || issue0_instr !== rtype(5'd8, 5'd8, 5'd10, 6'h20)) begin errors++; $display("FAIL lu_after got v=%0b i=%h", issue0_valid, issue0_instr); end
    next_cycle();
    drive_pair(rtype(5'd8, 5'd8, 5'd11, 6'h20), rtype(5'd5, 5'd6, 5'd4, 6'h25), 32'h310);
    next_cycle();
    fetch_valid = 1'b0;
    #1;
    checks++; if ({issue0_valid, issue1_valid} !== 2'b11) begin errors++; $display("FAIL lu_cleared got %b exp 11", {issue0_valid, issue1_valid}); end
    next_cycle();
  endtask

  task automatic test_struct_ctrl();
    drive_pair(itype(6'h23, 5'd9, 5'd8, 16'd0), itype(6'h2b, 5'd9, 5'd7, 16'd4), 32'h400);
    next_cycle();
    fetch_valid = 1'b0;
    #1;
    checks++; if ({issue0_valid, issue1_valid} !== 2'b10) begin errors++; $display("FAIL mem_pair got %b exp 10", {issue0_valid, issue1_valid}); end
    next_cycle();
    checks++; if (issue0_valid !== 1'b1 || issue0_pc !== 32'h404) begin errors++; $display("FAIL mem_sw got v=%0b pc=%h exp v=1 pc=404", issue0_valid, issue0_pc); end
    next_cycle();
    drive_pair(itype(6'h04, 5'd1, 5'd2, 16'd4), rtype(5'd2, 5'd3, 5'd1, 6'h20), 32'h410);
    next_cycle();
    fetch_valid = 1'b0;
    #1;
    checks++; if ({issue0_valid, issue1_valid} !== 2'b10) begin errors++; $display("FAIL ctrl_first got %b exp 10", {issue0_valid, issue1_valid}); end
    next_cycle();
    checks++; if (issue0_valid !== 1'b1 || issue0_pc !== 32'h414) begin errors++; $display("FAIL ctrl_add got v=%0b pc=%h exp v=1 pc=414", issue0_valid, issue0_pc); end
    next_cycle();
    drive_pair(rtype(5'd2, 5'd3, 5'd1, 6'h20), itype(6'h04, 5'd4, 5'd5, 16'd4), 32'h420);
    next_cycle();
    fetch_valid = 1'b0;
    #1;
    checks++; if ({issue0_valid, issue1_valid} !== 2'b11) begin errors++; $display("FAIL ctrl_second got %b exp 11", {issue0_valid, issue1_valid}); end
    next_cycle();
  endtask

  task automatic test_full_wrap();
    stall = 1'b1;
    drive_pair(rtype(5'd2, 5'd3, 5'd1, 6'h20), rtype(5'd5, 5'd6, 5'd4, 6'h25), 32'h500);
    next_cycle();
    drive_pair(rtype(5'd13, 5'd14, 5'd12, 6'h20), rtype(5'd16, 5'd17, 5'd15, 6'h25), 32'h508);
    #1;
    checks++; if (fetch_ready !== 1'b1 || occupancy !== 3'd2) begin errors++; $display("FAIL full_mid got rdy=%0b occ=%0d exp 1/2", fetch_ready, occupancy); end
    checks++; if (issue0_valid !== 1'b0) begin errors++; $display("FAIL full_stall got %0b exp 0", issue0_valid); end
    next_cycle();
    drive_pair(rtype(5'd21, 5'd22, 5'd20, 6'h20), rtype(5'd24, 5'd25, 5'd23, 6'h25), 32'h600);
    stall = 1'b0;
    #1;
    checks++; if (occupancy !== 3'd4 || fetch_ready !== 1'b0) begin errors++; $display("FAIL full_occ4 got occ=%0d rdy=%0b exp 4/0", occupancy, fetch_ready); end
    checks++; if ({issue0_valid, issue1_valid} !== 2'b11 || issue0_pc !== 32'h500 || issue1_pc !== 32'h504) begin errors++; $display("FAIL full_issueA got v=%b pc0=%h pc1=%h", {issue0_valid, issue1_valid}, issue0_pc, issue1_pc); end
    next_cycle();
    #1;
    checks++; if (occupancy !== 3'd2 || fetch_ready !== 1'b1) begin errors++; $display("FAIL full_occ2 got occ=%0d rdy=%0b exp 2/1", occupancy, fetch_ready); end
    checks++; if (issue1_valid !== 1'b1 || issue0_pc !== 32'h508) begin errors++; $display("FAIL full_issueB got v1=%0b pc0=%h exp 1/508", issue1_valid, issue0_pc); end
    next_cycle();
    fetch_valid = 1'b0;
    #1;
    checks++; if (occupancy !== 3'd2 || issue0_pc !== 32'h600 || issue1_pc !== 32'h604) begin errors++; $display("FAIL full_issueC got occ=%0d pc0=%h pc1=%h", occupancy, issue0_pc, issue1_pc); end
    next_cycle();
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL full_drain got %0d exp 0", occupancy); end
  endtask

  task automatic test_flush();
    stall = 1'b1;
    drive_pair(rtype(5'd2, 5'd3, 5'd1, 6'h20), rtype(5'd5, 5'd6, 5'd4, 6'h25), 32'h700);
    next_cycle();
    drive_pair(rtype(5'd2, 5'd3, 5'd1, 6'h20), rtype(5'd5, 5'd6, 5'd4, 6'h25), 32'h708);
    next_cycle();
    drive_pair(rtype(5'd2, 5'd3, 5'd1, 6'h20), rtype(5'd5, 5'd6, 5'd4, 6'h25), 32'h800);
    stall = 1'b0;
    flush = 1'b1;
    #1;
    checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL flush_pre_occ got %0d exp 4", occupancy); end
    checks++; if ({issue0_valid, issue1_valid} !== 2'b00) begin errors++; $display("FAIL flush_noissue got %b exp 00", {issue0_valid, issue1_valid}); end
    next_cycle();
    flush = 1'b0;
    fetch_valid = 1'b0;
    #1;
    checks++; if (occupancy !== 3'd0 || issue0_valid !== 1'b0 || fetch_ready !== 1'b1) begin errors++; $display("FAIL flush_post got occ=%0d v0=%0b rdy=%0b", occupancy, issue0_valid, fetch_ready); end
    stall = 1'b1;
    drive_pair(rtype(5'd2, 5'd3, 5'd1, 6'h20), rtype(5'd5, 5'd6, 5'd4, 6'h25), 32'h900);
    next_cycle();
    drive_pair(rtype(5'd2, 5'd3, 5'd1, 6'h20), rtype(5'd5, 5'd6, 5'd4, 6'h25), 32'h908);
    flush = 1'b1;
    #1;
    checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL flush2_ready got %0b exp 1", fetch_ready); end
    next_cycle();
    flush = 1'b0;
    fetch_valid = 1'b0;
    stall = 1'b0;
    #1;
    checks++; if (occupancy !== 3'd0 || issue0_valid !== 1'b0) begin errors++; $display("FAIL flush2_drop got occ=%0d v0=%0b exp 0/0", occupancy, issue0_valid); end
    next_cycle();
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL flush2_late got %0d exp 0", occupancy); end
  endtask

  task automatic test_async_reset();
    stall = 1'b1;
    drive_pair(rtype(5'd2, 5'd3, 5'd1, 6'h20), rtype(5'd5, 5'd6, 5'd4, 6'h25), 32'ha00);
    next_cycle();
    fetch_valid = 1'b0;
    stall = 1'b0;
    #1;
    checks++; if (issue0_valid !== 1'b1 || occupancy !== 3'd2) begin errors++; $display("FAIL arst_pre got v0=%0b occ=%0d exp 1/2", issue0_valid, occupancy); end
    rst = 1'b1;
    #1;
    checks++; if (occupancy !== 3'd0 || issue0_valid !== 1'b0 || fetch_ready !== 1'b1) begin errors++; $display("FAIL arst_now got occ=%0d v0=%0b rdy=%0b", occupancy, issue0_valid, fetch_ready); end
    next_cycle();
    rst = 1'b0;
    next_cycle();
    checks++; if (occupancy !== 3'd0 || issue0_valid !== 1'b0) begin errors++; $display("FAIL arst_after got occ=%0d v0=%0b", occupancy, issue0_valid); end
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    rst          = 1'b1;
    fetch_valid  = 1'b0;
    fetch_instr0 = 32'd0;
    fetch_instr1 = 32'd0;
    fetch_pc     = 32'd0;
    flush        = 1'b0;
    stall        = 1'b0;
    test_reset();
    test_independent();
    test_raw();
    test_load_use();
    test_struct_ctrl();
    test_full_wrap();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
